rate_divider_multi: RTL and testbench

Multi-channel programmable rate divider and tick generator, successor to the single-channel divider used for display refresh and game-speed timing. Each of `CHANNELS` independent channels has its own period, duty threshold and mode (free-running or one-shot), all loaded through one shared configuration write port. Each channel outputs a one-cycle `tick` at terminal count and a level `pulse` with programmable duty. It sits between the system clock and the game/display FSMs that need several unrelated rates.

---
 rtl/rate_divider_multi.sv | 86 ++++++++
 tb/tb_rate_divider_multi.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_divider_multi.sv
// Multi-channel programmable rate divider: per-channel down-counter with
// terminal-count tick, duty pulse, and free-running or one-shot mode.
module rate_divider_multi #(
   parameter int WIDTH    = 28,
   parameter int CHANNELS = 4,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                Clear_b,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WIDTH-1:0]    cfg_period,
   input  logic [WIDTH-1:0]    cfg_thresh,
   input  logic                cfg_oneshot,
   input  logic [CHANNELS-1:0] enable,
   input  logic [CHANNELS-1:0] start,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pulse,
   output logic [CHANNELS-1:0] busy
);

   logic [WIDTH-1:0]    period [CHANNELS];
   logic [WIDTH-1:0]    thresh [CHANNELS];
   logic [WIDTH-1:0]    q      [CHANNELS];
   logic [CHANNELS-1:0] oneshot;
   logic [CHANNELS-1:0] busy_r;
   logic [CHANNELS-1:0] tick_r;

   always_ff @(posedge clock) begin
      if (!Clear_b) begin
         for (int i = 0; i < CHANNELS; i++) begin
            period[i]  <= '0;
            thresh[i]  <= '0;
            q[i]       <= '0;
            oneshot[i] <= 1'b0;
            busy_r[i]  <= 1'b0;
            tick_r[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            tick_r[i] <= 1'b0;
            // A config write wins over counting and triggering on its channel.
            if (cfg_we && (int'(cfg_ch) < CHANNELS) && (int'(cfg_ch) == i)) begin
               period[i]  <= cfg_period;
               thresh[i]  <= cfg_thresh;
               oneshot[i] <= cfg_oneshot;
               q[i]       <= cfg_period;
               busy_r[i]  <= 1'b0;
            end else if (!oneshot[i]) begin
               busy_r[i] <= 1'b0;
               if (enable[i]) begin
                  if (q[i] == '0) begin
                     q[i]      <= period[i];
                     tick_r[i] <= 1'b1;
                  end else begin
                     q[i] <= q[i] - WIDTH'(1);
                  end
               end
            end else if (!busy_r[i]) begin
               if (start[i]) begin
                  q[i]      <= period[i];
                  busy_r[i] <= 1'b1;
               end
            end else if (enable[i]) begin
               if (q[i] == '0) begin
                  tick_r[i] <= 1'b1;
                  busy_r[i] <= 1'b0;
               end else begin
                  q[i] <= q[i] - WIDTH'(1);
               end
            end
         end
      end
   end

   always_comb begin
      pulse = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pulse[i] = (q[i] < thresh[i]) && (!oneshot[i] || busy_r[i]);
      end
   end

   assign tick = tick_r;
   assign busy = busy_r;

endmodule

// File: tb/tb_rate_divider_multi.sv
// Scoreboard bench for rate_divider_multi: expectations are queued as stimulus
// is applied and compared against tick/pulse/busy one edge later.
module tb_rate_divider_multi;

   localparam int W = 28;

   typedef struct packed {
      logic [3:0] t;
      logic [3:0] p;
      logic [3:0] b;
      logic [3:0] m;
   } exp_t;

   logic          clock = 1'b0;
   logic          Clear_b;
   logic          cfg_we;
   logic [1:0]    cfg_ch;
   logic [W-1:0]  cfg_period;
   logic [W-1:0]  cfg_thresh;
   logic          cfg_oneshot;
   logic [3:0]    enable;
   logic [3:0]    start;
   logic [3:0]    tick;
   logic [3:0]    pulse;
   logic [3:0]    busy;

   logic          c3_we;
   logic [1:0]    c3_ch;
   logic [7:0]    c3_period;
   logic [7:0]    c3_thresh;
   logic          c3_oneshot;
   logic [2:0]    c3_en;
   logic [2:0]    c3_start;
   logic [2:0]    c3_tick;
   logic [2:0]    c3_pulse;
   logic [2:0]    c3_busy;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   rate_divider_multi #(.WIDTH(W), .CHANNELS(4)) u_dut (
      .clock(clock), .Clear_b(Clear_b), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_period(cfg_period), .cfg_thresh(cfg_thresh), .cfg_oneshot(cfg_oneshot),
      .enable(enable), .start(start), .tick(tick), .pulse(pulse), .busy(busy)
   );

   rate_divider_multi #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
      .clock(clock), .Clear_b(Clear_b), .cfg_we(c3_we), .cfg_ch(c3_ch),
      .cfg_period(c3_period), .cfg_thresh(c3_thresh), .cfg_oneshot(c3_oneshot),
      .enable(c3_en), .start(c3_start), .tick(c3_tick), .pulse(c3_pulse), .busy(c3_busy)
   );

   always #5 clock = ~clock;

   task automatic clk();
      @(posedge clock);
      #1;
      cfg_we = 1'b0;
      c3_we  = 1'b0;
      start  = '0;
   endtask

   task automatic write_cfg(input int ch, input int per, input int th, input logic os);
      cfg_we      = 1'b1;
      cfg_ch      = 2'(ch);
      cfg_period  = W'(per);
      cfg_thresh  = W'(th);
      cfg_oneshot = os;
   endtask

   task automatic test_reset();
      Clear_b = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cfg_we = 1'($urandom); cfg_ch = 2'($urandom); cfg_period = W'($urandom);
         cfg_thresh = W'($urandom); cfg_oneshot = 1'($urandom);
         enable = 4'($urandom); start = 4'($urandom);
         sb.push_back({4'h0, 4'h0, 4'h0, 4'hF});
         clk();
         e = sb.pop_front();
         checks++;
         if ({tick, pulse, busy} !== {e.t, e.p, e.b}) begin
            errors++;
            $display("FAIL reset k=%0d got t/p/b %b/%b/%b want %b/%b/%b", k, tick, pulse, busy, e.t, e.p, e.b);
         end
      end
      Clear_b = 1'b1;
      enable  = '0;
      start   = '0;
      cfg_we  = 1'b0;
   endtask

   task automatic test_free_run();
      exp_t x;
      int   q;
      enable = 4'b0001;
      write_cfg(0, 3, 2, 1'b0);
      for (int k = 0; k < 12; k++) begin
         q = 3 - (k % 4);
         x = '0;
         x.m = 4'b0001;
         x.t[0] = (k > 0) && (k % 4 == 0);
         x.p[0] = (q < 2);
         sb.push_back(x);
         clk();
         e = sb.pop_front();
         checks++;
         if ({tick & e.m, pulse & e.m, busy & e.m} !== {e.t, e.p, e.b}) begin
            errors++;
            $display("FAIL free_run k=%0d got t/p/b %b/%b/%b want %b/%b/%b", k,
                     tick & e.m, pulse & e.m, busy & e.m, e.t, e.p, e.b);
         end
      end
   endtask

   task automatic test_enable_gating();
      exp_t x;
      int   n;
      int   q;
      enable = 4'b0000;
      write_cfg(0, 3, 2, 1'b0);
      for (int k = 0; k < 17; k++) begin
         if (k > 0) enable = (k % 2 == 1) ? 4'b0001 : 4'b0000;
         n = (k + 1) / 2;
         q = 3 - (n % 4);
         x = '0;
         x.m = 4'b0001;
         x.t[0] = (k % 2 == 1) && (n % 4 == 0);
         x.p[0] = (q < 2);
         sb.push_back(x);
         clk();
         e = sb.pop_front();
         checks++;
         if ({tick & e.m, pulse & e.m, busy & e.m} !== {e.t, e.p, e.b}) begin
            errors++;
            $display("FAIL enable_gating k=%0d got t/p/b %b/%b/%b want %b/%b/%b", k,
                     tick & e.m, pulse & e.m, busy & e.m, e.t, e.p, e.b);
         end
      end
      enable = '0;
   endtask

   task automatic test_oneshot();
      exp_t x;
      int   j;
      enable = 4'b0010;
      write_cfg(1, 5, 3, 1'b1);
      for (int k = 0; k < 11; k++) begin
         if (k == 1 || k == 3) start = 4'b0010;
         j = k - 1;
         x = '0;
         x.m = 4'b0010;
         if (j >= 0 && j <= 5) begin
            x.b[1] = 1'b1;
            x.p[1] = ((5 - j) < 3);
         end
         x.t[1] = (j == 6);
         sb.push_back(x);
         clk();
         e = sb.pop_front();
         checks++;
         if ({tick & e.m, pulse & e.m, busy & e.m} !== {e.t, e.p, e.b}) begin
            errors++;
            $display("FAIL oneshot k=%0d got t/p/b %b/%b/%b want %b/%b/%b", k,
                     tick & e.m, pulse & e.m, busy & e.m, e.t, e.p, e.b);
         end
      end
      enable = '0;
   endtask

   task automatic test_collision();
      exp_t x;
      enable = 4'b0100;
      write_cfg(2, 3, 0, 1'b0);
      for (int k = 0; k < 13; k++) begin
         if (k == 4) write_cfg(2, 5, 6, 1'b0);
         x = '0;
         x.m = 4'b0100;
         x.t[2] = (k == 10);
         x.p[2] = (k >= 4);
         sb.push_back(x);
         clk();
         e = sb.pop_front();
         checks++;
         if ({tick & e.m, pulse & e.m, busy & e.m} !== {e.t, e.p, e.b}) begin
            errors++;
            $display("FAIL collision k=%0d got t/p/b %b/%b/%b want %b/%b/%b", k,
                     tick & e.m, pulse & e.m, busy & e.m, e.t, e.p, e.b);
         end
      end
      enable = '0;
   endtask

   task automatic test_period_zero();
      exp_t x;
      enable = 4'b1000;
      write_cfg(3, 0, 0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (k == 6) enable = 4'b0000;
         x = '0;
         x.m = 4'b1000;
         x.t[3] = (k >= 1 && k <= 5);
         sb.push_back(x);
         clk();
         e = sb.pop_front();
         checks++;
         if ({tick & e.m, pulse & e.m, busy & e.m} !== {e.t, e.p, e.b}) begin
            errors++;
            $display("FAIL period_zero k=%0d got t/p/b %b/%b/%b want %b/%b/%b", k,
                     tick & e.m, pulse & e.m, busy & e.m, e.t, e.p, e.b);
         end
      end
   endtask

   task automatic test_multi_channel();
      exp_t x;
      enable = '0;
      for (int c = 0; c < 4; c++) begin
         write_cfg(c, c + 1, 0, 1'b0);
         clk();
      end
      enable = 4'b1111;
      for (int k = 1; k <= 24; k++) begin
         x = '0;
         x.m = 4'b1111;
         for (int c = 0; c < 4; c++) x.t[c] = (k % (c + 2) == 0);
         sb.push_back(x);
         clk();
         e = sb.pop_front();
         checks++;
         if ({tick & e.m, pulse & e.m, busy & e.m} !== {e.t, e.p, e.b}) begin
            errors++;
            $display("FAIL multi_channel k=%0d got t/p/b %b/%b/%b want %b/%b/%b", k,
                     tick & e.m, pulse & e.m, busy & e.m, e.t, e.p, e.b);
         end
      end
      enable = '0;
   endtask

   task automatic test_out_of_range();
      exp_t x;
      int   q;
      c3_en = 3'b001;
      c3_we = 1'b1; c3_ch = 2'd0; c3_period = 8'd2; c3_thresh = 8'd1; c3_oneshot = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k == 2) begin
            c3_we = 1'b1; c3_ch = 2'd3; c3_period = 8'd0; c3_thresh = 8'hFF; c3_oneshot = 1'b0;
         end
         q = 2 - (k % 3);
         x = '0;
         x.m = 4'b0111;
         x.t[0] = (k > 0) && (k % 3 == 0);
         x.p[0] = (q < 1);
         sb.push_back(x);
         clk();
         e = sb.pop_front();
         checks++;
         if ({{1'b0, c3_tick} & e.m, {1'b0, c3_pulse} & e.m, {1'b0, c3_busy} & e.m} !== {e.t, e.p, e.b}) begin
            errors++;
            $display("FAIL out_of_range k=%0d got t/p/b %b/%b/%b want %b/%b/%b", k,
                     c3_tick, c3_pulse, c3_busy, e.t[2:0], e.p[2:0], e.b[2:0]);
         end
      end
      c3_en = '0;
   endtask

   task automatic test_reset_mid_oneshot();
      exp_t x;
      enable = 4'b0010;
      write_cfg(1, 5, 3, 1'b1);
      clk();
      start = 4'b0010;
      clk();
      clk();
      clk();
      x = '0;
      x.m = 4'b0010;
      x.b[1] = 1'b1;
      sb.push_back(x);
      e = sb.pop_front();
      checks++;
      if ({tick & e.m, pulse & e.m, busy & e.m} !== {e.t, e.p, e.b}) begin
         errors++;
         $display("FAIL reset_mid_busy got t/p/b %b/%b/%b want %b/%b/%b",
                  tick & e.m, pulse & e.m, busy & e.m, e.t, e.p, e.b);
      end
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            Clear_b = 1'b0;
            write_cfg(0, 7, 9, 1'b0);
         end else begin
            Clear_b = 1'b1;
            enable  = 4'b0000;
         end
         sb.push_back({4'h0, 4'h0, 4'h0, 4'hF});
         clk();
         e = sb.pop_front();
         checks++;
         if ({tick, pulse, busy} !== {e.t, e.p, e.b}) begin
            errors++;
            $display("FAIL reset_mid_oneshot k=%0d got t/p/b %b/%b/%b want %b/%b/%b",
                     k, tick, pulse, busy, e.t, e.p, e.b);
         end
      end
   endtask

   initial begin
      Clear_b = 1'b0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_thresh = '0; cfg_oneshot = 1'b0;
      enable = '0; start = '0;
      c3_we = 1'b0; c3_ch = '0; c3_period = '0; c3_thresh = '0; c3_oneshot = 1'b0;
      c3_en = '0; c3_start = '0;
      #2;
      test_reset();
      test_free_run();
      test_enable_gating();
      test_oneshot();
      test_collision();
      test_period_zero();
      test_multi_channel();
      test_out_of_range();
      test_reset_mid_oneshot();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
